// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the EX3 execute stage
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] result;
        logic [63:0] store_data;
        logic [7:0]  byte_en;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        is_load;
        logic        is_store;
        logic        misalign;
    } ex3_entry_t;

endpackage

// File: rtl/riscv_ex3_stage_if.sv
// rtl/riscv_ex3_stage_if.sv - EX2 input bundle and EX3 output bundle of the EX3 stage
interface riscv_ex3_stage_if;
    logic [63:0] ex2_pc;
    logic [31:0] ex2_inst;
    logic [63:0] ex2_alu_result;
    logic [63:0] ex2_rs2_data;
    logic [4:0]  ex2_rd_addr;
    logic [2:0]  ex2_funct3;
    logic        ex2_valid;
    logic        flush;
    logic        mem_ready;
    logic        ex3_ready;
    logic [63:0] ex3_pc;
    logic [31:0] ex3_inst;
    logic [63:0] ex3_result;
    logic [63:0] ex3_store_data;
    logic [7:0]  ex3_byte_en;
    logic [4:0]  ex3_rd_addr;
    logic [2:0]  ex3_funct3;
    logic        ex3_is_load;
    logic        ex3_is_store;
    logic        ex3_misalign;
    logic        ex3_valid;
    logic [31:0] ex3_stall_cnt;

    modport master (
        output ex2_pc, ex2_inst, ex2_alu_result, ex2_rs2_data, ex2_rd_addr,
               ex2_funct3, ex2_valid, flush, mem_ready,
        input  ex3_ready, ex3_pc, ex3_inst, ex3_result, ex3_store_data,
               ex3_byte_en, ex3_rd_addr, ex3_funct3, ex3_is_load, ex3_is_store,
               ex3_misalign, ex3_valid, ex3_stall_cnt
    );

    modport slave (
        input  ex2_pc, ex2_inst, ex2_alu_result, ex2_rs2_data, ex2_rd_addr,
               ex2_funct3, ex2_valid, flush, mem_ready,
        output ex3_ready, ex3_pc, ex3_inst, ex3_result, ex3_store_data,
               ex3_byte_en, ex3_rd_addr, ex3_funct3, ex3_is_load, ex3_is_store,
               ex3_misalign, ex3_valid, ex3_stall_cnt
    );
endinterface

// File: rtl/riscv_ex3_lsu_align.sv
// rtl/riscv_ex3_lsu_align.sv - byte-enable, store-lane and misalignment generation
module riscv_ex3_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            is_mem,
    output logic [7:0]      byte_en,
    output logic [XLEN-1:0] store_data,
    output logic            misalign
);

    mem_size_e  size;
    logic [2:0] off;
    logic [7:0] mask;
    logic [2:0] low_mask;
    logic       mis_raw;
    logic       unused_bits;

    // Only the byte offset and the size field matter; signedness (funct3[2]) does not.
    assign unused_bits = ^{addr[XLEN-1:3], funct3[2]};

    always_comb begin
        size     = mem_size_e'(funct3[1:0]);
        off      = addr[2:0];
        mask     = 8'hFF;
        low_mask = 3'b111;
        case (size)
            MEM_B:   begin mask = 8'h01; low_mask = 3'b000; end
            MEM_H:   begin mask = 8'h03; low_mask = 3'b001; end
            MEM_W:   begin mask = 8'h0F; low_mask = 3'b011; end
            default: begin mask = 8'hFF; low_mask = 3'b111; end
        endcase
        mis_raw    = |(off & low_mask);
        byte_en    = 8'h00;
        store_data = rs2;
        misalign   = 1'b0;
        if (is_mem) begin
            store_data = rs2 << {off, 3'b000};
            byte_en    = mask << off;
            if (mis_raw && MISALIGN_TRAP) begin
                byte_en  = 8'h00;
                misalign = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_ex3_stage.sv
// rtl/riscv_ex3_stage.sv - EX3 stage: load/store classification, lane alignment, 2-entry elastic buffer
module riscv_ex3_stage
    import riscv_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_ex3_stage_if.slave  io
);

    occ_state_e  state, state_nxt;
    logic        out_valid, skid_valid, ready_q;
    ex3_entry_t  out_q, skid_q, in_e;
    logic [31:0] stall_q;

    logic        is_load, is_store, accept;
    logic [7:0]  al_byte_en;
    logic [XLEN-1:0] al_store_data;
    logic        al_misalign;

    assign is_load  = (io.ex2_inst[6:0] == OPC_LOAD);
    assign is_store = (io.ex2_inst[6:0] == OPC_STORE);
    assign accept   = io.ex2_valid & ready_q & ~io.flush;

    riscv_ex3_lsu_align #(
        .XLEN          (XLEN),
        .MISALIGN_TRAP (MISALIGN_TRAP)
    ) u_align (
        .addr       (io.ex2_alu_result),
        .rs2        (io.ex2_rs2_data),
        .funct3     (io.ex2_funct3),
        .is_mem     (is_load | is_store),
        .byte_en    (al_byte_en),
        .store_data (al_store_data),
        .misalign   (al_misalign)
    );

    always_comb begin
        in_e            = '0;
        in_e.pc         = io.ex2_pc;
        in_e.inst       = io.ex2_inst;
        in_e.result     = io.ex2_alu_result;
        in_e.store_data = al_store_data;
        in_e.byte_en    = al_byte_en;
        in_e.rd         = io.ex2_rd_addr;
        in_e.funct3     = io.ex2_funct3;
        in_e.is_load    = is_load;
        in_e.is_store   = is_store;
        in_e.misalign   = al_misalign;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
            OCC_ONE: begin
                if (accept && !io.mem_ready)      state_nxt = OCC_TWO;
                else if (!accept && io.mem_ready) state_nxt = OCC_EMPTY;
            end
            OCC_TWO:   if (io.mem_ready) state_nxt = OCC_ONE;
            default:   state_nxt = OCC_EMPTY;
        endcase
        if (io.flush) state_nxt = OCC_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OCC_EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state      <= state_nxt;
            out_valid  <= (state_nxt != OCC_EMPTY);
            skid_valid <= (state_nxt == OCC_TWO);
            ready_q    <= (state_nxt != OCC_TWO);
        end
    end

    // Payload registers carry no reset; the valids above qualify them.
    always_ff @(posedge clk) begin
        if ((state == OCC_EMPTY && accept) || (state == OCC_ONE && accept && io.mem_ready))
            out_q <= in_e;
        else if (state == OCC_TWO && io.mem_ready)
            out_q <= skid_q;
        if (state == OCC_ONE && accept && !io.mem_ready)
            skid_q <= in_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= 32'h0;
        else if (out_valid && !io.mem_ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign io.ex3_ready      = ready_q;
    assign io.ex3_valid      = out_valid;
    assign io.ex3_pc         = out_q.pc;
    assign io.ex3_inst       = out_q.inst;
    assign io.ex3_result     = out_q.result;
    assign io.ex3_store_data = out_q.store_data;
    assign io.ex3_byte_en    = out_q.byte_en;
    assign io.ex3_rd_addr    = out_q.rd;
    assign io.ex3_funct3     = out_q.funct3;
    assign io.ex3_is_load    = out_q.is_load;
    assign io.ex3_is_store   = out_q.is_store;
    assign io.ex3_misalign   = out_q.misalign;
    assign io.ex3_stall_cnt  = stall_q;

    // Upstream must hold off while the stage is full, except when the entry is being flushed anyway.
    ex2_valid_while_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(io.ex2_valid && !ready_q && !io.flush));

    logic unused_skid;
    assign unused_skid = skid_valid;

endmodule

// File: tb/tb_riscv_ex3_stage.sv
// tb/tb_riscv_ex3_stage.sv - self-checking bench for riscv_ex3_stage against a queue model
module tb_riscv_ex3_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } raw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] d_pc, d_alu, d_rs2;
    logic [31:0] d_inst;
    logic [4:0]  d_rd;
    logic [2:0]  d_f3;
    logic        d_valid, d_flush, d_mem_ready;

    riscv_ex3_stage_if ift ();
    riscv_ex3_stage_if ifn ();

    assign ift.ex2_pc = d_pc;          assign ifn.ex2_pc = d_pc;
    assign ift.ex2_inst = d_inst;      assign ifn.ex2_inst = d_inst;
    assign ift.ex2_alu_result = d_alu; assign ifn.ex2_alu_result = d_alu;
    assign ift.ex2_rs2_data = d_rs2;   assign ifn.ex2_rs2_data = d_rs2;
    assign ift.ex2_rd_addr = d_rd;     assign ifn.ex2_rd_addr = d_rd;
    assign ift.ex2_funct3 = d_f3;      assign ifn.ex2_funct3 = d_f3;
    assign ift.ex2_valid = d_valid;    assign ifn.ex2_valid = d_valid;
    assign ift.flush = d_flush;        assign ifn.flush = d_flush;
    assign ift.mem_ready = d_mem_ready; assign ifn.mem_ready = d_mem_ready;

    riscv_ex3_stage #(.XLEN(64), .MISALIGN_TRAP(1'b1)) dut_t (.clk(clk), .rst_n(rst_n), .io(ift));
    riscv_ex3_stage #(.XLEN(64), .MISALIGN_TRAP(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .io(ifn));

    int total = 0;
    int bad = 0;

    raw_t        mq[$];
    bit          m_ready = 1'b1;
    logic [31:0] m_stall = 32'h0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(logic [6:0] opc, logic [2:0] f3);
        return {17'h0, f3, 5'h0, opc};
    endfunction

    function automatic void expect_of(raw_t r, bit trap, output logic [7:0] be,
                                      output logic [63:0] sd, output logic mis,
                                      output logic ld, output logic st);
        int nb;
        int off;
        logic [63:0] m;
        ld = (r.inst[6:0] == 7'b0000011);
        st = (r.inst[6:0] == 7'b0100011);
        nb = 1 << r.f3[1:0];
        off = int'(r.alu % 64'd8);
        if (ld || st) begin
            m   = (64'd1 << nb) - 64'd1;
            be  = 8'((m << off) & 64'hFF);
            sd  = r.rs2 << (8 * off);
            mis = (r.alu % 64'(nb)) != 64'd0;
            if (mis) begin
                if (trap) be = 8'h00;
                else      mis = 1'b0;
            end
        end else begin
            be  = 8'h00;
            sd  = r.rs2;
            mis = 1'b0;
        end
    endfunction

    task automatic check_one(string nm, bit trap, logic valid, logic ready, logic [31:0] stall,
                             logic [63:0] pc, logic [31:0] inst, logic [63:0] res,
                             logic [63:0] sd, logic [7:0] be, logic [4:0] rd, logic [2:0] f3,
                             logic isl, logic iss, logic mis);
        logic [7:0] e_be;
        logic [63:0] e_sd;
        logic e_mis, e_ld, e_st;
        chk({nm, ".valid"}, 64'(valid), 64'(mq.size() > 0));
        chk({nm, ".ready"}, 64'(ready), 64'(m_ready));
        chk({nm, ".stall"}, 64'(stall), 64'(m_stall));
        if (mq.size() > 0) begin
            expect_of(mq[0], trap, e_be, e_sd, e_mis, e_ld, e_st);
            chk({nm, ".pc"}, pc, mq[0].pc);
            chk({nm, ".inst"}, 64'(inst), 64'(mq[0].inst));
            chk({nm, ".result"}, res, mq[0].alu);
            chk({nm, ".store_data"}, sd, e_sd);
            chk({nm, ".byte_en"}, 64'(be), 64'(e_be));
            chk({nm, ".rd"}, 64'(rd), 64'(mq[0].rd));
            chk({nm, ".funct3"}, 64'(f3), 64'(mq[0].f3));
            chk({nm, ".is_load"}, 64'(isl), 64'(e_ld));
            chk({nm, ".is_store"}, 64'(iss), 64'(e_st));
            chk({nm, ".misalign"}, 64'(mis), 64'(e_mis));
        end
    endtask

    task automatic check_outputs();
        check_one("trap", 1'b1, ift.ex3_valid, ift.ex3_ready, ift.ex3_stall_cnt, ift.ex3_pc,
                  ift.ex3_inst, ift.ex3_result, ift.ex3_store_data, ift.ex3_byte_en,
                  ift.ex3_rd_addr, ift.ex3_funct3, ift.ex3_is_load, ift.ex3_is_store,
                  ift.ex3_misalign);
        check_one("notrap", 1'b0, ifn.ex3_valid, ifn.ex3_ready, ifn.ex3_stall_cnt, ifn.ex3_pc,
                  ifn.ex3_inst, ifn.ex3_result, ifn.ex3_store_data, ifn.ex3_byte_en,
                  ifn.ex3_rd_addr, ifn.ex3_funct3, ifn.ex3_is_load, ifn.ex3_is_store,
                  ifn.ex3_misalign);
    endtask

    function automatic void model_step();
        raw_t cur;
        bit acc;
        cur = '{pc: d_pc, inst: d_inst, alu: d_alu, rs2: d_rs2, rd: d_rd, f3: d_f3};
        acc = d_valid && m_ready && !d_flush;
        if (mq.size() > 0 && !d_mem_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (d_flush) mq.delete();
        else begin
            if (mq.size() > 0 && d_mem_ready) void'(mq.pop_front());
            if (acc) mq.push_back(cur);
        end
        m_ready = (mq.size() < 2);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(logic v, logic [31:0] inst, logic [63:0] alu, logic [63:0] rs2,
                         logic [2:0] f3, logic [63:0] pc);
        d_valid = v; d_inst = inst; d_alu = alu; d_rs2 = rs2; d_f3 = f3; d_pc = pc;
        d_rd = pc[6:2];
    endtask

    initial begin
        d_flush = 1'b0; d_mem_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 64'h0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(ift.ex3_valid), 64'd0);
        chk("rst.ready", 64'(ift.ex3_ready), 64'd1);
        chk("rst.stall", 64'(ift.ex3_stall_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // SD aligned
        drive(1'b1, mk_inst(7'b0100011, 3'd3), 64'h1000, 64'h1122334455667788, 3'd3, 64'h100);
        tick();
        chk("sd.is_store", 64'(ift.ex3_is_store), 64'd1);
        chk("sd.byte_en", 64'(ift.ex3_byte_en), 64'hFF);
        chk("sd.store_data", ift.ex3_store_data, 64'h1122334455667788);
        chk("sd.misalign", 64'(ift.ex3_misalign), 64'd0);

        // SH at offset 6
        drive(1'b1, mk_inst(7'b0100011, 3'd1), 64'h1006, 64'hBEEF, 3'd1, 64'h104);
        tick();
        chk("sh.byte_en", 64'(ift.ex3_byte_en), 64'hC0);
        chk("sh.store_data", ift.ex3_store_data, 64'hBEEF000000000000);

        // LW misaligned, both trap settings
        drive(1'b1, mk_inst(7'b0000011, 3'd2), 64'h1002, 64'h0, 3'd2, 64'h108);
        tick();
        chk("lw.trap.misalign", 64'(ift.ex3_misalign), 64'd1);
        chk("lw.trap.byte_en", 64'(ift.ex3_byte_en), 64'h00);
        chk("lw.notrap.misalign", 64'(ifn.ex3_misalign), 64'd0);
        chk("lw.notrap.byte_en", 64'(ifn.ex3_byte_en), 64'h3C);

        // ADDI
        drive(1'b1, mk_inst(7'b0010011, 3'd0), 64'h5, 64'h77, 3'd0, 64'h10C);
        tick();
        chk("addi.byte_en", 64'(ift.ex3_byte_en), 64'h0);
        chk("addi.is_load", 64'(ift.ex3_is_load), 64'd0);
        chk("addi.is_store", 64'(ift.ex3_is_store), 64'd0);
        chk("addi.result", ift.ex3_result, 64'h5);
        drive(1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 64'h0);
        tick();

        // backpressure: A then B fill both entries
        d_mem_ready = 1'b0;
        drive(1'b1, mk_inst(7'b0110011, 3'd0), 64'hA, 64'h1, 3'd0, 64'h200);
        tick();
        drive(1'b1, mk_inst(7'b0110011, 3'd0), 64'hB, 64'h2, 3'd0, 64'h204);
        tick();
        chk("full.ready", 64'(ift.ex3_ready), 64'd0);
        drive(1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 64'h0);
        repeat (3) tick();
        chk("full.stall", 64'(ift.ex3_stall_cnt), 64'd4);
        d_mem_ready = 1'b1;
        chk("order.first", ift.ex3_pc, 64'h200);
        tick();
        chk("order.second", ift.ex3_pc, 64'h204);
        tick();
        chk("drain.ready", 64'(ift.ex3_ready), 64'd1);
        chk("drain.valid", 64'(ift.ex3_valid), 64'd0);

        // flush while full, with a same-cycle input that must be dropped
        d_mem_ready = 1'b0;
        drive(1'b1, mk_inst(7'b0000011, 3'd3), 64'h2000, 64'h0, 3'd3, 64'h300);
        tick();
        drive(1'b1, mk_inst(7'b0000011, 3'd3), 64'h2008, 64'h0, 3'd3, 64'h304);
        tick();
        drive(1'b1, mk_inst(7'b0000011, 3'd3), 64'h2010, 64'h0, 3'd3, 64'h308);
        d_flush = 1'b1;
        tick();
        d_flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 64'h0);
        chk("flush.valid", 64'(ift.ex3_valid), 64'd0);
        chk("flush.ready", 64'(ift.ex3_ready), 64'd1);
        d_mem_ready = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 3))
                0: opc = 7'b0000011;
                1: opc = 7'b0100011;
                2: opc = 7'b0010011;
                default: opc = 7'b0110011;
            endcase
            d_flush = ($urandom_range(0, 24) == 0);
            d_mem_ready = ($urandom_range(0, 2) != 0);
            drive((m_ready || d_flush) ? 1'($urandom_range(0, 1)) : 1'b0,
                  {$urandom} & 32'hFFFF_FF80 | 32'(opc), {$urandom, $urandom},
                  {$urandom, $urandom}, 3'($urandom_range(0, 7)), {32'h0, $urandom});
            tick();
        end
        d_flush = 1'b0;

        // asynchronous reset in the middle of a stall
        d_mem_ready = 1'b0;
        drive(1'b1, mk_inst(7'b0100011, 3'd3), 64'h3000, 64'h9, 3'd3, 64'h400);
        tick();
        drive(1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 64'h0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(ift.ex3_valid), 64'd0);
        chk("arst.stall", 64'(ift.ex3_stall_cnt), 64'd0);
        chk("arst.ready", 64'(ift.ex3_ready), 64'd1);
        mq.delete();
        m_ready = 1'b1;
        m_stall = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d_mem_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
